// File: rtl/floo_vc_inject_port_pkg.sv
// Flit and header types used by the VC injection port.
// Also holds the injection FSM encoding shared by the RTL and its checkers.
package floo_vc_inject_port_pkg;

  localparam int unsigned VcIdWidth    = 2;
  localparam int unsigned DstWidth     = 4;
  localparam int unsigned PayloadWidth = 32;

  typedef struct packed {
    logic [VcIdWidth-1:0] vc_id;
    logic                 last;
    logic [DstWidth-1:0]  dst_id;
  } hdr_t;

  typedef struct packed {
    hdr_t                    hdr;
    logic [PayloadWidth-1:0] payload;
  } flit_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } inj_state_e;

endpackage

// File: rtl/floo_vc_credit_counter.sv
// One saturating up/down credit counter for a single router input VC buffer.
// Reset value is Depth, i.e. the downstream buffer starts empty.
module floo_vc_credit_counter #(
  parameter int unsigned Depth = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic dec,
  input  logic inc,
  output logic avail,
  output logic full
);

  localparam int unsigned CntWidth = $clog2(Depth + 1);
  localparam logic [CntWidth-1:0] Full = CntWidth'(Depth);

  logic [CntWidth-1:0] count_q;

  // Simultaneous send and return cancel out; a lone return never exceeds Depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= Full;
    end else if (inc && !dec && (count_q != Full)) begin
      count_q <= count_q + 1'b1;
    end else if (dec && !inc && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign avail = (count_q != '0);
  assign full  = (count_q == Full);

  credit_overflow: assert property (@(posedge clk) disable iff (rst)
    !(inc && !dec && (count_q == Full)));

  credit_underflow: assert property (@(posedge clk) disable iff (rst)
    !(dec && !inc && (count_q == '0)));

endmodule

// File: rtl/floo_vc_inject_port.sv
// Credit-based VC injection stage in front of a floo_vc_router input port.
// Assigns a VC per packet, keeps wormhole packets on one VC, never overruns a VC buffer.
module floo_vc_inject_port #(
  parameter int unsigned NumVCWidth    = 2,
  parameter int unsigned NumVC         = 4,
  parameter int unsigned VCDepth       = 2,
  parameter bit          AllowFallback = 1'b1,
  parameter type         flit_t        = floo_vc_inject_port_pkg::flit_t
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  flit_t                               data_i,
  output logic                                data_v_o,
  output flit_t                               data_o,
  input  logic                                credit_v_i,
  input  logic [NumVCWidth-1:0]               credit_id_i,
  output logic                                idle_o,
  output floo_vc_inject_port_pkg::inj_state_e state_o
);

  import floo_vc_inject_port_pkg::*;

  typedef logic [NumVCWidth-1:0] vc_id_t;

  inj_state_e       state_q, state_d;
  vc_id_t           locked_vc_q;
  vc_id_t           pref_vc, fb_vc, head_vc, send_vc;
  logic             pref_ok, fb_found, head_ok, send;
  logic [NumVC-1:0] vc_avail, vc_full, vc_dec, vc_inc;
  flit_t            out_flit, data_q;
  logic             data_v_q;

  // Handshake: a flit transfers on a clock edge where valid_i && ready_o. ready_o
  // never looks at valid_i; upstream keeps data_i stable while valid_i is high.
  assign send = valid_i && ready_o;

  assign pref_vc = data_i.hdr.vc_id;
  assign pref_ok = (32'(pref_vc) < NumVC) && vc_avail[pref_vc];

  // Lowest-index VC with a free buffer slot.
  always_comb begin
    fb_found = 1'b0;
    fb_vc    = '0;
    for (int i = NumVC - 1; i >= 0; i--) begin
      if (vc_avail[i]) begin
        fb_found = 1'b1;
        fb_vc    = vc_id_t'(i);
      end
    end
  end

  assign head_ok = pref_ok || (AllowFallback && fb_found);
  assign head_vc = pref_ok ? pref_vc : fb_vc;

  // FSM: state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      locked_vc_q <= '0;
    end else begin
      state_q <= state_d;
      if (send && (state_q == ST_IDLE)) begin
        locked_vc_q <= head_vc;
      end
    end
  end

  // FSM: next state. Single-flit packets never leave IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (send && !data_i.hdr.last) state_d = ST_LOCKED;
      ST_LOCKED: if (send && data_i.hdr.last)  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. A locked packet stalls on its own VC even if others have room.
  always_comb begin
    ready_o = 1'b0;
    send_vc = head_vc;
    case (state_q)
      ST_IDLE: begin
        ready_o = head_ok && !rst_i;
        send_vc = head_vc;
      end
      ST_LOCKED: begin
        ready_o = vc_avail[locked_vc_q] && !rst_i;
        send_vc = locked_vc_q;
      end
      default: begin
        ready_o = 1'b0;
        send_vc = head_vc;
      end
    endcase
  end

  always_comb begin
    out_flit           = data_i;
    out_flit.hdr.vc_id = send_vc;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_v_q <= 1'b0;
      data_q   <= '0;
    end else begin
      data_v_q <= send;
      if (send) begin
        data_q <= out_flit;
      end
    end
  end

  for (genvar v = 0; v < NumVC; v++) begin : gen_credit
    assign vc_dec[v] = send && (send_vc == vc_id_t'(v));
    assign vc_inc[v] = credit_v_i && (credit_id_i == vc_id_t'(v));

    floo_vc_credit_counter #(
      .Depth (VCDepth)
    ) i_credit_counter (
      .clk   (clk_i),
      .rst   (rst_i),
      .dec   (vc_dec[v]),
      .inc   (vc_inc[v]),
      .avail (vc_avail[v]),
      .full  (vc_full[v])
    );
  end

  assign data_v_o = data_v_q;
  assign data_o   = data_q;
  assign idle_o   = (state_q == ST_IDLE) && (&vc_full);
  assign state_o  = state_q;

  credit_id_range: assert property (@(posedge clk_i) disable iff (rst_i)
    credit_v_i |-> (32'(credit_id_i) < NumVC));

endmodule

// File: tb/tb_floo_vc_inject_port.sv
// Directed bench for floo_vc_inject_port: scoreboarded main instance (fallback on)
// plus a second instance with fallback off checked inline.
module tb_floo_vc_inject_port;

  import floo_vc_inject_port_pkg::*;

  localparam int FlitW = $bits(flit_t);

  // clock / reset
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT (AllowFallback = 1)
  logic       valid_i, ready_o, data_v_o, credit_v_i, idle_o;
  flit_t      data_i, data_o;
  logic [1:0] credit_id_i;
  inj_state_e state_o;

  // second DUT (AllowFallback = 0)
  logic       b_valid, b_ready, b_data_v, b_credit_v, b_idle;
  flit_t      b_data, b_data_o;
  logic [1:0] b_credit_id;
  inj_state_e b_state;

  floo_vc_inject_port #(
    .NumVCWidth(2), .NumVC(4), .VCDepth(2), .AllowFallback(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .data_v_o(data_v_o), .data_o(data_o),
    .credit_v_i(credit_v_i), .credit_id_i(credit_id_i),
    .idle_o(idle_o), .state_o(state_o)
  );

  floo_vc_inject_port #(
    .NumVCWidth(2), .NumVC(4), .VCDepth(2), .AllowFallback(1'b0)
  ) dut_nofb (
    .clk_i(clk), .rst_i(rst_i), .valid_i(b_valid), .ready_o(b_ready),
    .data_i(b_data), .data_v_o(b_data_v), .data_o(b_data_o),
    .credit_v_i(b_credit_v), .credit_id_i(b_credit_id),
    .idle_o(b_idle), .state_o(b_state)
  );

  // scoreboard
  logic [FlitW-1:0] exp_q[$];
  int               exp_cyc_q[$];
  logic [FlitW-1:0] mon_exp;
  int               mon_cyc;
  int               n_vec = 0;
  int               n_err = 0;
  int               last_acc_cyc = 0;
  int               first_cyc = 0;
  int               waited = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic flit_t mk(input logic [1:0] vc, input logic last,
                               input logic [3:0] dst, input logic [31:0] pl);
    flit_t f;
    f.hdr.vc_id  = vc;
    f.hdr.last   = last;
    f.hdr.dst_id = dst;
    f.payload    = pl;
    return f;
  endfunction

  // monitor: every output pulse pops one expectation (flit and arrival cycle)
  always @(negedge clk) begin
    if (data_v_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_flit: got 0x%0h, expected no flit", data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        check("flit_out", 64'(data_o), 64'(mon_exp));
        check("flit_cycle", 64'(cyc), 64'(mon_cyc));
      end
    end
  end

  // driver tasks: all called at a negedge, return at the negedge after acceptance
  task automatic send(input logic [1:0] pref, input logic last, input logic [3:0] dst,
                      input logic [31:0] pl, input logic [1:0] exp_vc,
                      input int max_wait, output int wt);
    flit_t f, e;
    f  = mk(pref, last, dst, pl);
    wt = 0;
    valid_i = 1'b1;
    data_i  = f;
    #1;
    while (!ready_o && wt < max_wait) begin
      @(negedge clk);
      wt++;
      #1;
    end
    if (!ready_o) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: ready_o stayed 0 for %0d cycles, expected 1", wt);
    end else begin
      e = f;
      e.hdr.vc_id = exp_vc;
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + 1);
      last_acc_cyc = cyc;
    end
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic ret_credit(input logic [1:0] vc);
    credit_v_i  = 1'b1;
    credit_id_i = vc;
    @(negedge clk);
    credit_v_i  = 1'b0;
  endtask

  task automatic ret_stream(input logic [1:0] vc, input int n);
    for (int i = 0; i < n; i++) begin
      credit_v_i  = 1'b1;
      credit_id_i = vc;
      @(negedge clk);
    end
    credit_v_i = 1'b0;
  endtask

  task automatic expect_ready(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      check("ready_stall", 64'(ready_o), 64'(v));
      @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rv;
    rst_i = 1'b1;
    valid_i = 1'b0; data_i = '0; credit_v_i = 1'b0; credit_id_i = '0;
    b_valid = 1'b0; b_data = '0; b_credit_v = 1'b0; b_credit_id = '0;

    // reset behaviour
    repeat (3) @(negedge clk);
    valid_i = 1'b1; data_i = mk(2'd0, 1'b1, 4'h0, 32'h1);
    b_valid = 1'b1; b_data = mk(2'd0, 1'b1, 4'h0, 32'h1);
    #1;
    check("ready_in_reset", 64'(ready_o), 64'd0);
    check("b_ready_in_reset", 64'(b_ready), 64'd0);
    check("data_v_in_reset", 64'(data_v_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("ready_after_reset", 64'(ready_o), 64'd1);
    check("idle_after_reset", 64'(idle_o), 64'd1);
    check("state_after_reset", 64'(state_o), 64'(ST_IDLE));
    check("data_o_after_reset", 64'(data_o), 64'd0);
    valid_i = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);

    // single-flit packets on VC1; third falls back to VC0
    send(2'd1, 1'b1, 4'h3, 32'hA000_0001, 2'd1, 5, waited);
    send(2'd1, 1'b1, 4'h4, 32'hA000_0002, 2'd1, 5, waited);
    check("state_single_flit", 64'(state_o), 64'(ST_IDLE));
    send(2'd1, 1'b1, 4'h5, 32'hA000_0003, 2'd0, 5, waited);
    ret_credit(2'd1);
    ret_credit(2'd1);
    ret_credit(2'd0);
    #1;
    check("idle_after_fallback", 64'(idle_o), 64'd1);
    @(negedge clk);

    // 4-flit packet on VC2, random body vc ids, credits returned in step
    fork
      begin
        send(2'd2, 1'b0, 4'h7, 32'hC0DE_0000, 2'd2, 5, waited);
        first_cyc = last_acc_cyc;
        for (int i = 1; i < 3; i++) begin
          rv = 2'($urandom_range(0, 3));
          send(rv, 1'b0, 4'h7, 32'hC0DE_0000 + i, 2'd2, 5, waited);
        end
        rv = 2'($urandom_range(0, 3));
        send(rv, 1'b1, 4'h7, 32'hC0DE_FFFF, 2'd2, 5, waited);
      end
      ret_stream(2'd2, 4);
    join
    #1;
    check("pkt4_consecutive", 64'(last_acc_cyc - first_cyc), 64'd3);
    check("state_after_pkt4", 64'(state_o), 64'(ST_IDLE));
    check("idle_after_pkt4", 64'(idle_o), 64'd1);
    @(negedge clk);

    // sustained send + same-cycle return on VC3 for 20 cycles
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          send(2'd3, 1'b1, 4'(i), $urandom, 2'd3, 5, waited);
          if (i == 0) first_cyc = last_acc_cyc;
        end
      end
      ret_stream(2'd3, 20);
    join
    #1;
    check("sustained_span", 64'(last_acc_cyc - first_cyc), 64'd19);
    check("idle_after_sustained", 64'(idle_o), 64'd1);
    @(negedge clk);

    // locked VC2 runs dry mid-packet while VC0 is full
    send(2'd2, 1'b0, 4'h9, 32'h5555_0001, 2'd2, 5, waited);
    send(2'd0, 1'b0, 4'h9, 32'h5555_0002, 2'd2, 5, waited);
    #1;
    check("state_locked", 64'(state_o), 64'(ST_LOCKED));
    fork
      send(2'd0, 1'b1, 4'h9, 32'h5555_0003, 2'd2, 10, waited);
      begin
        expect_ready(1'b0, 3);
        ret_credit(2'd2);
      end
    join
    check("stall_wait_cycles", 64'(waited), 64'd4);
    ret_credit(2'd2);
    ret_credit(2'd2);
    #1;
    check("state_after_stall", 64'(state_o), 64'(ST_IDLE));
    check("idle_after_stall", 64'(idle_o), 64'd1);
    @(negedge clk);

    // reset in the middle of a packet that has drained VC1
    send(2'd1, 1'b0, 4'h2, 32'h7777_0001, 2'd1, 5, waited);
    send(2'd3, 1'b0, 4'h2, 32'h7777_0002, 2'd1, 5, waited);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("data_v_after_midreset", 64'(data_v_o), 64'd0);
    check("idle_after_midreset", 64'(idle_o), 64'd1);
    check("state_after_midreset", 64'(state_o), 64'(ST_IDLE));
    @(negedge clk);
    send(2'd1, 1'b1, 4'h2, 32'h7777_0003, 2'd1, 5, waited);
    check("head_after_reset_wait", 64'(waited), 64'd0);
    ret_credit(2'd1);
    #1;
    check("idle_end_main", 64'(idle_o), 64'd1);
    @(negedge clk);

    // fallback disabled: third flit on VC1 stalls until a VC1 credit returns
    b_valid = 1'b1;
    b_data  = mk(2'd1, 1'b1, 4'h5, 32'hB000_0001);
    #1 check("b_ready_1", 64'(b_ready), 64'd1);
    @(negedge clk);
    check("b_data_v_1", 64'(b_data_v), 64'd1);
    check("b_flit_1", 64'(b_data_o), 64'(mk(2'd1, 1'b1, 4'h5, 32'hB000_0001)));
    b_data = mk(2'd1, 1'b1, 4'h6, 32'hB000_0002);
    #1 check("b_ready_2", 64'(b_ready), 64'd1);
    @(negedge clk);
    check("b_flit_2", 64'(b_data_o), 64'(mk(2'd1, 1'b1, 4'h6, 32'hB000_0002)));
    b_data = mk(2'd1, 1'b1, 4'h7, 32'hB000_0003);
    #1 check("b_ready_stall_0", 64'(b_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("b_ready_stall", 64'(b_ready), 64'd0);
      check("b_data_v_stall", 64'(b_data_v), 64'd0);
    end
    b_credit_v = 1'b1; b_credit_id = 2'd1;
    @(negedge clk);
    b_credit_v = 1'b0;
    #1 check("b_ready_after_credit", 64'(b_ready), 64'd1);
    @(negedge clk);
    b_valid = 1'b0;
    check("b_data_v_3", 64'(b_data_v), 64'd1);
    check("b_flit_3", 64'(b_data_o), 64'(mk(2'd1, 1'b1, 4'h7, 32'hB000_0003)));
    b_credit_v = 1'b1; b_credit_id = 2'd1;
    repeat (2) @(negedge clk);
    b_credit_v = 1'b0;
    #1 check("b_idle_end", 64'(b_idle), 64'd1);

    // final report
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
